// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch_queue instruction fetch front end.
// FETCH_QUEUE_REDIRECT_EN adds the DRAIN state used to flush in-flight bursts.
package fetch_pkg;

  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned BEAT_BYTES     = 8;
  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned WINDOW_BYTES   = 15;

  // Request tag fields: {READ, MEMORY, 8'b0}
  localparam logic       TAG_READ   = 1'b1;
  localparam logic [3:0] TAG_MEMORY = 4'b0001;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StActive
`ifdef FETCH_QUEUE_REDIRECT_EN
    , StDrain
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_window_rotate.sv
// Extracts the decode window from the circular byte queue starting at the read pointer.
// Byte k of the window lands in win_bytes[8*(WINDOW_BYTES-1-k) +: 8].
module fetch_window_rotate #(
  parameter int unsigned BUF_BYTES    = 128,
  parameter int unsigned WINDOW_BYTES = 15,
  localparam int unsigned PTR_W       = $clog2(BUF_BYTES)
) (
  input  logic [7:0]                buffer [BUF_BYTES],
  input  logic [PTR_W-1:0]          rd_ptr,
  output logic [8*WINDOW_BYTES-1:0] win_bytes
);

  always_comb begin
    win_bytes = '0;
    // Pointer arithmetic is PTR_W wide, so the index wraps at the buffer end.
    for (int k = 0; k < int'(WINDOW_BYTES); k++) begin
      win_bytes[8*(int'(WINDOW_BYTES)-1-k) +: 8] = buffer[rd_ptr + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: line requests, beat packing into a circular byte queue, decode
// window. Define FETCH_QUEUE_REDIRECT_EN to compile in redirect/flush support.
module fetch_queue #(
  parameter int unsigned BUF_BYTES    = 128,
  parameter int unsigned LINE_BYTES   = fetch_pkg::LINE_BYTES,
  parameter int unsigned WINDOW_BYTES = fetch_pkg::WINDOW_BYTES,
  parameter int unsigned TAG_W        = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_rip,
  output logic                      reqcyc,
  output logic [63:0]               req,
  output logic [TAG_W-1:0]          reqtag,
  input  logic                      reqack,
  input  logic                      respcyc,
  input  logic [63:0]               resp,
  output logic                      respack,
  output logic [8*WINDOW_BYTES-1:0] win_bytes,
  output logic [7:0]                win_count,
  output logic                      win_valid,
  output logic [63:0]               win_rip,
  input  logic [3:0]                consume
);
  import fetch_pkg::*;

  localparam int unsigned PTR_W     = $clog2(BUF_BYTES);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  fetch_state_t     state_q;
  logic [63:0]      fetch_rip_q;
  logic [5:0]       skip_q;
  logic [2:0]       beat_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [7:0]       count_q;
  logic [63:0]      rip_q;
  logic             reqcyc_q;
  logic [63:0]      req_q;
  logic [TAG_W-1:0] reqtag_q;
  logic [7:0]       buf_q [BUF_BYTES];

  logic redirect;
`ifdef FETCH_QUEUE_REDIRECT_EN
  assign redirect = redirect_valid;
`else
  assign redirect = 1'b0;
  logic unused_redirect;
  assign unused_redirect = ^{redirect_valid, redirect_rip};
`endif

  logic       beat_in;
  logic       beat_drop;
  logic [2:0] beat_start;
  logic [3:0] beat_bytes;
  logic       beat_last;

  always_comb begin
    beat_in    = respcyc && (state_q == StWait || state_q == StActive);
    beat_drop  = beat_q < skip_q[5:3];
    beat_start = (beat_q == skip_q[5:3]) ? skip_q[2:0] : 3'd0;
    beat_bytes = (beat_in && !beat_drop && !redirect) ? 4'd8 - 4'(beat_start) : 4'd0;
    beat_last  = beat_q == 3'(BEATS_PER_LINE - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      fetch_rip_q <= entry & LINE_MASK;
      skip_q      <= entry[5:0];
      beat_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rip_q       <= entry;
      reqcyc_q    <= 1'b0;
      req_q       <= '0;
      reqtag_q    <= '0;
    end else if (redirect) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rip_q       <= redirect_rip;
      fetch_rip_q <= redirect_rip & LINE_MASK;
      skip_q      <= redirect_rip[5:0];
`ifdef FETCH_QUEUE_REDIRECT_EN
      case (state_q)
        StReq: begin
          // An accepted request still returns a full burst that must be soaked up.
          reqcyc_q <= 1'b0;
          beat_q   <= '0;
          state_q  <= reqack ? StDrain : StIdle;
        end
        StWait, StActive: begin
          beat_q  <= beat_q + 3'(respcyc);
          state_q <= (respcyc && beat_last) ? StIdle : StDrain;
        end
        StDrain: begin
          if (respcyc) begin
            beat_q <= beat_q + 3'd1;
            if (beat_last) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
`endif
    end else begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(consume);
      rip_q    <= rip_q + 64'(consume);
      wr_ptr_q <= wr_ptr_q + PTR_W'(beat_bytes);
      count_q  <= count_q + 8'(beat_bytes) - 8'(consume);
      case (state_q)
        StIdle: begin
          // Only one line is ever in flight, so room for a full line is the only condition.
          if (count_q <= 8'(BUF_BYTES - LINE_BYTES)) begin
            state_q  <= StReq;
            reqcyc_q <= 1'b1;
            req_q    <= fetch_rip_q;
            reqtag_q <= TAG_W'({TAG_READ, TAG_MEMORY, 8'b0});
          end
        end
        StReq: begin
          if (reqack) begin
            state_q  <= StWait;
            reqcyc_q <= 1'b0;
            beat_q   <= '0;
          end
        end
        StWait, StActive: begin
          if (respcyc) begin
            beat_q <= beat_q + 3'd1;
            if (beat_last) begin
              state_q     <= StIdle;
              fetch_rip_q <= fetch_rip_q + 64'(LINE_BYTES);
              skip_q      <= '0;
            end else begin
              state_q <= StActive;
            end
          end
        end
`ifdef FETCH_QUEUE_REDIRECT_EN
        StDrain: begin
          if (respcyc) begin
            beat_q <= beat_q + 3'd1;
            if (beat_last) state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && beat_bytes != 4'd0) begin
      for (int k = 0; k < int'(BEAT_BYTES); k++) begin
        if (3'(k) >= beat_start) begin
          buf_q[wr_ptr_q + PTR_W'(k) - PTR_W'(beat_start)] <= resp[8*k +: 8];
        end
      end
    end
  end

  fetch_window_rotate #(
    .BUF_BYTES    (BUF_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_rotate (
    .buffer    (buf_q),
    .rd_ptr    (rd_ptr_q),
    .win_bytes (win_bytes)
  );

  assign respack   = respcyc;
  assign reqcyc    = reqcyc_q;
  assign req       = req_q;
  assign reqtag    = reqtag_q;
  assign win_count = count_q;
  assign win_valid = count_q >= 8'(WINDOW_BYTES);
  assign win_rip   = rip_q;

  // Retiring bytes that are not in the queue means the decoder has lost sync with fetch.
  consume_le_count: assert property (@(posedge clk) disable iff (reset)
    8'(consume) <= win_count)
    else $fatal(1, "consume %0d exceeds win_count %0d", consume, win_count);

endmodule
